// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter: round-robin arbiter sequencing NREQ requesters' writes into one shared
// level-sensitive latch, holding enable HOLD cycles plus one hold-margin cycle, then verifying and acking.
module latch_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2,
  localparam int IW   = $clog2(NREQ),
  localparam int CW   = $clog2(HOLD + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] wdata_i,
  output logic [NREQ-1:0]       ack_o,
  output logic [WIDTH-1:0]      latch_d_o,
  output logic                  latch_en_o,
  input  logic [WIDTH-1:0]      latch_q_i,
  output logic [IW-1:0]         grant_id_o,
  output logic                  busy_o,
  output logic                  wr_err_o
);
  typedef enum logic [1:0] {IDLE, WRITE, SETTLE, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, grant_q, grant_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d, win_data;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [2*NREQ-1:0] rot;
  logic en_q, en_d, busy_q, busy_d, err_q, err_d, hit;
  int s;
  // rotate requests so the rr pointer lands on bit 0; the lowest set bit wins
  always_comb begin
    rot = {req_i, req_i} >> rr_q;
    win = '0;
    hit = 1'b0;
    s = 0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) begin
        s = int'(rr_q) + k;
        win = IW'(s >= NREQ ? s - NREQ : s);
        hit = 1'b1;
      end
    win_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (win == IW'(i)) win_data = wdata_i[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  always_comb
    case (state_q)
      IDLE:    state_d = hit ? WRITE : IDLE;
      WRITE:   state_d = cnt_q == '0 ? SETTLE : WRITE;
      SETTLE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  always_comb begin
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    busy_d  = busy_q;
    err_d   = err_q;
    en_d    = 1'b0;
    ack_d   = '0;
    case (state_q)
      IDLE:
        if (hit) begin
          grant_d = win;
          data_d  = win_data;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = CW'(HOLD - 1);
        end
      WRITE: begin
        en_d  = cnt_q != '0;
        cnt_d = cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
      end
      // enable is already low here, so latch_q holds what was captured
      SETTLE: begin
        err_d = err_q | (latch_q_i != data_q);
        ack_d = NREQ'(1) << grant_q;
      end
      default: begin
        rr_d   = grant_q == IW'(NREQ - 1) ? '0 : grant_q + 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end
  assign ack_o      = ack_q;
  assign latch_d_o  = data_q;
  assign latch_en_o = en_q;
  assign grant_id_o = grant_q;
  assign busy_o     = busy_q;
  assign wr_err_o   = err_q;
endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb_latch_write_arbiter: scoreboard bench for latch_write_arbiter driving a behavioural latch
// whose captured value can be corrupted through a bit mask.
module tb_latch_write_arbiter;
  localparam int NREQ = 4, WIDTH = 8, HOLD = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req_i = '0, ack_o;
  logic [NREQ*WIDTH-1:0] wdata_i = '0;
  logic [WIDTH-1:0] latch_d_o, latch_q_i, mask = 8'hFF;
  logic latch_en_o, busy_o, wr_err_o;
  logic [1:0] grant_id_o;
  int checks = 0, errors = 0, gap;
  typedef struct {int id; logic [WIDTH-1:0] data;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always_latch if (latch_en_o) latch_q_i = latch_d_o & mask;

  latch_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .wdata_i(wdata_i), .ack_o(ack_o),
    .latch_d_o(latch_d_o), .latch_en_o(latch_en_o), .latch_q_i(latch_q_i),
    .grant_id_o(grant_id_o), .busy_o(busy_o), .wr_err_o(wr_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    req_i = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [3:0] r, input logic [3:0] r_after, input int id,
                    input logic [7:0] d, input logic err, output int g);
    int n;
    exp_t e;
    req_i = r;
    wdata_i[id*WIDTH +: WIDTH] = d;
    sb.push_back('{id: id, data: d});
    g = 0;
    do begin @(negedge clk); g++; end while (!latch_en_o && g < 20);
    if (!latch_en_o) begin
      chk("grant_timeout", 32'd0, 32'd1);
      void'(sb.pop_back());
      req_i = r_after;
      return;
    end
    chk("busy_wr", 32'(busy_o), 32'd1);
    n = 0;
    while (latch_en_o && n < 20) begin
      chk("latch_d_wr", 32'(latch_d_o), 32'(d));
      chk("grant_wr", 32'(grant_id_o), 32'(id));
      wdata_i = $urandom;
      n++;
      @(negedge clk);
    end
    chk("en_cycles", 32'(n), 32'(HOLD));
    chk("latch_d_settle", 32'(latch_d_o), 32'(d));
    chk("ack_early", 32'(ack_o), 32'd0);
    @(negedge clk);
    chk("ack_seen", 32'(|ack_o), 32'd1);
    if (|ack_o && sb.size() > 0) begin
      e = sb.pop_front();
      chk("ack_onehot", 32'(ack_o), 32'd1 << e.id);
      chk("grant_id", 32'(grant_id_o), 32'(e.id));
      chk("latch_d_ack", 32'(latch_d_o), 32'(e.data));
    end
    chk("wr_err", 32'(wr_err_o), 32'(err));
    req_i = r_after;
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack_o), 32'd0);
    chk("busy_idle", 32'(busy_o), 32'd0);
    chk("en_idle", 32'(latch_en_o), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_en", 32'(latch_en_o), 32'd0);
    chk("rst_d", 32'(latch_d_o), 32'd0);
    chk("rst_grant", 32'(grant_id_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(wr_err_o), 32'd0);
    rst_n = 1'b1;
    wr(4'b0100, 4'b0000, 2, 8'hA5, 1'b0, gap);
    chk("single_gap", 32'(gap), 32'd1);
    rst_pulse();
    wr(4'b1010, 4'b1000, 1, 8'h5A, 1'b0, gap);
    wr(4'b1000, 4'b0000, 3, 8'hC3, 1'b0, gap);
    chk("req3_gap", 32'(gap), 32'd1);
    rst_pulse();
    for (int i = 0; i < 20; i++) begin
      wr(4'b1111, i == 19 ? 4'b0000 : 4'b1111, i % 4, 8'($urandom), 1'b0, gap);
      chk("rr_gap", 32'(gap), 32'd1);
    end
    mask = 8'hFE;
    wr(4'b0001, 4'b0000, 0, 8'hFF, 1'b1, gap);
    mask = 8'hFF;
    wr(4'b0100, 4'b0000, 2, 8'h3C, 1'b1, gap);
    req_i = 4'b0100;
    wdata_i[2*WIDTH +: WIDTH] = 8'h77;
    gap = 0;
    do begin @(negedge clk); gap++; end while (!latch_en_o && gap < 20);
    chk("abort_grant", 32'(latch_en_o), 32'd1);
    @(negedge clk);
    chk("abort_en_second", 32'(latch_en_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_en", 32'(latch_en_o), 32'd0);
    chk("abort_ack", 32'(ack_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_grant_id", 32'(grant_id_o), 32'd0);
    chk("abort_d", 32'(latch_d_o), 32'd0);
    chk("abort_err", 32'(wr_err_o), 32'd0);
    req_i = '0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(ack_o), 32'd0);
    end
    rst_n = 1'b1;
    wr(4'b1111, 4'b0000, 0, 8'h81, 1'b0, gap);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
